pc_gen_unit: RTL and testbench

Parametrised program-counter generator for the RISC-V core. It holds the PC and resolves the next PC from the branch/jump type and ALU flags, advancing only on a valid/ready handshake with fetch. A return-address stack (RAS) predicts return targets. A fault state machine traps misaligned taken targets and holds fetch until a redirect.

---
 rtl/pc_gen_unit.sv | 132 +++++++++++++
 tb/tb_pc_gen_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_unit.sv
// Program-counter generator: resolves the next PC from branch type and ALU flags,
// keeps a circular return-address stack, and traps misaligned taken targets.
module pc_gen_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              RAS_DEPTH = 4,
    parameter int              IALIGN    = 4
) (
    input  logic            CLK,
    input  logic            RST,
    output logic            pc_valid,
    input  logic            pc_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] return_pc,
    input  logic [2:0]      branch_type,
    input  logic [XLEN-1:0] pc_offset,
    input  logic [XLEN-1:0] target_pc,
    input  logic            alu_zero,
    input  logic            alu_neg,
    input  logic            link,
    input  logic            ret,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_valid,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc,
    input  logic            fault_clr,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = (IALIGN == 2) ?
        {{(XLEN-1){1'b1}}, 1'b0} : {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {HOLD, RUN, FAULT} state_t;

    state_t            state, next_state;
    logic              taken, is_jump, is_jalr;
    logic [XLEN-1:0]   jump_target, next_pc;
    logic              misaligned, handshake, advance;
    logic [XLEN-1:0]   ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  top;
    logic [CNT_W-1:0]  count;
    logic              ras_empty, do_push, do_pop, do_replace;

    always_comb begin
        taken   = 1'b0;
        is_jump = 1'b0;
        is_jalr = 1'b0;
        case (branch_type)
            3'b001: begin taken = 1'b1; is_jump = 1'b1; end
            3'b010: begin taken = 1'b1; is_jump = 1'b1; is_jalr = 1'b1; end
            3'b011: taken = alu_zero;
            3'b100: taken = !alu_zero;
            3'b101: taken = alu_neg;
            3'b110: taken = !alu_neg;
            default: taken = 1'b0;
        endcase
    end

    assign return_pc   = pc + XLEN'(4);
    assign jump_target = is_jalr ? {target_pc[XLEN-1:1], 1'b0} : pc + pc_offset;
    assign next_pc     = taken ? jump_target : return_pc;
    assign misaligned  = taken && ((jump_target & ~ALIGN_MASK) != '0);
    assign handshake   = (state == RUN) && pc_ready;
    assign advance     = handshake && !misaligned;

    always_comb begin
        next_state = state;
        pc_valid   = 1'b0;
        fault      = 1'b0;
        case (state)
            HOLD:  next_state = RUN;
            RUN: begin
                pc_valid = 1'b1;
                if (handshake && misaligned) next_state = FAULT;
            end
            FAULT: begin
                fault = 1'b1;
                if (fault_clr) next_state = RUN;
            end
            default: next_state = HOLD;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= HOLD;
        else     state <= next_state;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc       <= RESET_PC;
            fault_pc <= '0;
        end else begin
            if (advance)
                pc <= next_pc;
            else if (state == FAULT && fault_clr)
                pc <= redirect_pc & ALIGN_MASK;
            if (handshake && misaligned)
                fault_pc <= jump_target;
        end
    end

    // A pop-then-push on an empty stack degenerates to a plain push.
    assign ras_empty  = (count == '0);
    assign do_pop     = advance && is_jalr && ret && !link && !ras_empty;
    assign do_replace = advance && is_jalr && ret && link && !ras_empty;
    assign do_push    = advance && is_jump && link && !(is_jalr && ret && !ras_empty);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            top   <= '0;
            count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
        end else if (do_push) begin
            top                   <= top + PTR_W'(1);
            ras_mem[top + PTR_W'(1)] <= return_pc;
            if (count != DEPTH_CNT) count <= count + CNT_W'(1);
        end else if (do_pop) begin
            top   <= top - PTR_W'(1);
            count <= count - CNT_W'(1);
        end else if (do_replace) begin
            ras_mem[top] <= return_pc;
        end
    end

    assign ras_valid = !ras_empty;
    assign ras_top   = ras_empty ? '0 : ras_mem[top];

endmodule

// File: tb/tb_pc_gen_unit.sv
// Self-checking bench for pc_gen_unit: directed steps from the test plan followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_pc_gen_unit;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        pc_ready, alu_zero, alu_neg, link, ret, fault_clr;
    logic [2:0]  branch_type;
    logic [31:0] pc_offset, target_pc, redirect_pc;

    logic        pc_valid, ras_valid, fault;
    logic [31:0] pc, return_pc, ras_top, fault_pc;
    logic        a2_pc_valid, a2_ras_valid, a2_fault;
    logic [31:0] a2_pc, a2_return_pc, a2_ras_top, a2_fault_pc;

    int passed = 0;
    int total  = 0;

    logic [31:0] m_pc, m_fpc;
    int          m_mode;
    logic [31:0] m_ras [$];

    always #5 CLK = ~CLK;

    pc_gen_unit #(.XLEN(32), .RESET_PC(32'h0), .RAS_DEPTH(DEPTH), .IALIGN(4)) dut (
        .CLK(CLK), .RST(RST), .pc_valid(pc_valid), .pc_ready(pc_ready), .pc(pc),
        .return_pc(return_pc), .branch_type(branch_type), .pc_offset(pc_offset),
        .target_pc(target_pc), .alu_zero(alu_zero), .alu_neg(alu_neg), .link(link),
        .ret(ret), .ras_top(ras_top), .ras_valid(ras_valid), .fault(fault),
        .fault_pc(fault_pc), .fault_clr(fault_clr), .redirect_pc(redirect_pc)
    );

    pc_gen_unit #(.XLEN(32), .RESET_PC(32'h0), .RAS_DEPTH(DEPTH), .IALIGN(2)) dut_a2 (
        .CLK(CLK), .RST(RST), .pc_valid(a2_pc_valid), .pc_ready(pc_ready), .pc(a2_pc),
        .return_pc(a2_return_pc), .branch_type(branch_type), .pc_offset(pc_offset),
        .target_pc(target_pc), .alu_zero(alu_zero), .alu_neg(alu_neg), .link(link),
        .ret(ret), .ras_top(a2_ras_top), .ras_valid(a2_ras_valid), .fault(a2_fault),
        .fault_pc(a2_fault_pc), .fault_clr(fault_clr), .redirect_pc(redirect_pc)
    );

    task automatic model_reset();
        m_pc   = 32'h0;
        m_fpc  = 32'h0;
        m_mode = 0;
        m_ras.delete();
    endtask

    // Mode 0 = holding after reset, 1 = running, 2 = trapped on a misaligned target.
    task automatic model_step();
        logic        tk;
        logic [31:0] tgt, ra;
        ra = m_pc + 32'd4;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (pc_ready) begin
                case (branch_type)
                    3'd1, 3'd2: tk = 1'b1;
                    3'd3:       tk = alu_zero;
                    3'd4:       tk = !alu_zero;
                    3'd5:       tk = alu_neg;
                    3'd6:       tk = !alu_neg;
                    default:    tk = 1'b0;
                endcase
                tgt = (branch_type == 3'd2) ? (target_pc & ~32'h1) : (m_pc + pc_offset);
                if (tk && (tgt % 32'd4) != 32'd0) begin
                    m_fpc  = tgt;
                    m_mode = 2;
                end else begin
                    m_pc = tk ? tgt : ra;
                    if (branch_type == 3'd2 && ret && !link) begin
                        if (m_ras.size() > 0) void'(m_ras.pop_back());
                    end else if (branch_type == 3'd2 && ret && link && m_ras.size() > 0) begin
                        m_ras[m_ras.size()-1] = ra;
                    end else if ((branch_type == 3'd1 || branch_type == 3'd2) && link) begin
                        m_ras.push_back(ra);
                        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                    end
                end
            end
        end else begin
            if (fault_clr) begin
                m_pc   = redirect_pc & ~32'h3;
                m_mode = 1;
            end
        end
    endtask

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_output();
        check_value("pc", pc, m_pc);
        check_value("pc_valid", 32'(pc_valid), 32'(m_mode == 1));
        check_value("fault", 32'(fault), 32'(m_mode == 2));
        check_value("fault_pc", fault_pc, m_fpc);
        check_value("return_pc", return_pc, m_pc + 32'd4);
        check_value("ras_valid", 32'(ras_valid), 32'(m_ras.size() > 0));
        check_value("ras_top", ras_top, (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0);
    endtask

    task automatic apply_stimulus(input logic [2:0] bt, input logic [31:0] off,
                                  input logic [31:0] tgt, input logic z, input logic n,
                                  input logic lk, input logic rt, input logic rdy,
                                  input logic clr, input logic [31:0] redir);
        branch_type = bt;  pc_offset = off;  target_pc = tgt;
        alu_zero    = z;   alu_neg   = n;    link      = lk;  ret = rt;
        pc_ready    = rdy; fault_clr = clr;  redirect_pc = redir;
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        check_output();
    endtask

    // Asynchronous reset pulse placed mid-cycle, checked before any clock edge.
    task automatic pulse_reset();
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check_output();
        #3;
        RST = 1'b0;
    endtask

    logic [31:0] pop_exp [4];
    logic [31:0] saved_pc;

    initial begin
        pop_exp = '{32'h404, 32'h304, 32'h204, 32'h104};
        RST = 1'b1;
        apply_stimulus(3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0);
        model_reset();
        #12;
        check_output();
        check_value("reset_valid_const", 32'(pc_valid), 32'h0);
        check_value("a2_reset_pc", a2_pc, 32'h0);
        RST = 1'b0;

        tick();
        check_value("valid_after_hold", 32'(pc_valid), 32'h1);
        tick();
        tick();
        check_value("seq_pc8", pc, 32'h8);

        apply_stimulus(3'd1, 32'hFFFF_FFF4, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0);
        tick();
        check_value("pc_top", pc, 32'hFFFF_FFFC);
        apply_stimulus(3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0);
        tick();
        check_value("pc_wrap", pc, 32'h0);

        apply_stimulus(3'd1, 32'h100, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0);
        tick();
        apply_stimulus(3'd3, 32'h20, 32'h0, 1, 0, 0, 0, 1, 0, 32'h0);
        tick();
        check_value("beq_taken", pc, 32'h120);
        apply_stimulus(3'd1, 32'hFFFF_FFE0, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0);
        tick();
        apply_stimulus(3'd3, 32'h20, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0);
        tick();
        check_value("beq_not_taken", pc, 32'h104);
        apply_stimulus(3'd6, 32'h40, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0);
        tick();
        check_value("bge_taken", pc, 32'h144);
        apply_stimulus(3'd5, 32'h40, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0);
        tick();
        check_value("blt_not_taken", pc, 32'h148);

        pulse_reset();
        apply_stimulus(3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0);
        tick();
        apply_stimulus(3'd1, 32'h10, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0);
        tick();
        // fault_clr asserted on the entering edge must be ignored.
        apply_stimulus(3'd2, 32'h0, 32'h203, 0, 0, 0, 0, 1, 1, 32'h80);
        tick();
        check_value("jalr_fault_pc", fault_pc, 32'h202);
        check_value("jalr_pc_held", pc, 32'h10);
        check_value("a2_jalr_pc", a2_pc, 32'h202);
        check_value("a2_no_fault", 32'(a2_fault), 32'h0);
        apply_stimulus(3'd1, 32'h40, 32'h0, 0, 0, 1, 0, 1, 0, 32'h0);
        tick();
        apply_stimulus(3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 1, 32'h83);
        tick();
        check_value("redirect_pc", pc, 32'h80);
        check_value("redirect_run", 32'(pc_valid), 32'h1);

        pulse_reset();
        apply_stimulus(3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(3'd1, 32'h100, 32'h0, 0, 0, 1, 0, 1, 0, 32'h0);
            tick();
        end
        check_value("ras_full_top", ras_top, 32'h404);
        for (int i = 0; i < 4; i++) begin
            check_value("ras_pop_top", ras_top, pop_exp[i]);
            apply_stimulus(3'd2, 32'h0, pop_exp[i], 0, 0, 0, 1, 1, 0, 32'h0);
            tick();
        end
        check_value("ras_drained", 32'(ras_valid), 32'h0);
        apply_stimulus(3'd2, 32'h0, 32'h100, 0, 0, 0, 1, 1, 0, 32'h0);
        tick();
        check_value("ras_empty_pop_valid", 32'(ras_valid), 32'h0);
        check_value("ras_empty_pop_top", ras_top, 32'h0);

        apply_stimulus(3'd1, 32'h100, 32'h0, 0, 0, 1, 0, 1, 0, 32'h0);
        tick();
        saved_pc = m_pc;
        apply_stimulus(3'd4, 32'h40, 32'h0, 0, 0, 1, 1, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) tick();
        check_value("stall_pc", pc, saved_pc);
        pc_ready = 1'b1;
        tick();
        check_value("bne_after_stall", pc, saved_pc + 32'h40);

        apply_stimulus(3'd1, 32'h6, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0);
        tick();
        check_value("fault_entered", 32'(fault), 32'h1);
        pulse_reset();
        check_value("reset_clears_ras", 32'(ras_valid), 32'h0);
        check_value("reset_clears_fault", 32'(fault), 32'h0);

        apply_stimulus(3'd0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 0, 32'h0);
        tick();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] off, tgt;
            off = $urandom & 32'h3FC;
            if ($urandom_range(0, 7) == 0) off = off | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) off = -off;
            tgt = $urandom & 32'hFFC;
            if ($urandom_range(0, 7) == 0) tgt = tgt | 32'($urandom_range(1, 3));
            apply_stimulus(3'($urandom_range(0, 7)), off, tgt,
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                           $urandom);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
